hazard_ctrl_v2: RTL and testbench

- Parametrised successor to the 5-stage MIPS hazard detector.
- Adds multi-cycle load-use bubbles, a mul/div busy tracker on HI/LO, and a memory-stall freeze that overrides everything, on top of branch/JR/jump flushing.
- Sits beside the decode stage.
- Drives the PC enable, IF/ID hold, the global pipeline freeze and the IF/ID and ID/EX flushes.

---
 rtl/hazard_ctrl_v2_if.sv | 45 ++++
 rtl/hazard_ctrl_v2.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl_v2.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_v2_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_v2_if
// Description : Decode/EX hazard sideband bundle between pipeline and
//               hazard_ctrl_v2 (master = pipeline, slave = hazard unit).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_v2_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] iRs_D;
    logic [REG_AW-1:0] iRt_D;
    logic              iUseRs_D;
    logic              iUseRt_D;
    logic [REG_AW-1:0] iRd_E;
    logic              iLoad_E;
    logic              iMulDiv_D;
    logic              iHiLo_D;
    logic              iMemStall;
    logic              iBranch_E;
    logic              iJR_E;
    logic              iJump_D;
    logic              oPCEnable;
    logic              oStallIFID;
    logic              oFreeze;
    logic              oFlushIFID;
    logic              oFlushIDEX;
    logic              oMdStart;
    logic              oMdBusy;

    modport master (
        output iRs_D, iRt_D, iUseRs_D, iUseRt_D, iRd_E, iLoad_E,
               iMulDiv_D, iHiLo_D, iMemStall, iBranch_E, iJR_E, iJump_D,
        input  oPCEnable, oStallIFID, oFreeze, oFlushIFID, oFlushIDEX,
               oMdStart, oMdBusy
    );

    modport slave (
        input  iRs_D, iRt_D, iUseRs_D, iUseRt_D, iRd_E, iLoad_E,
               iMulDiv_D, iHiLo_D, iMemStall, iBranch_E, iJR_E, iJump_D,
        output oPCEnable, oStallIFID, oFreeze, oFlushIFID, oFlushIDEX,
               oMdStart, oMdBusy
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_v2
// Description : MIPS decode-side hazard unit: memory freeze, control flush,
//               multi-cycle load-use bubbles and HI/LO mul/div busy tracking.
//               Optional macro HAZ_PERF_EN adds stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_v2 #(
    parameter int REG_AW   = 5,
    parameter int LU_STALL = 1,
    parameter int MD_LAT   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_ctrl_v2_if.slave     bus
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]         oStallCnt,
    output logic [31:0]         oFlushCnt
`endif
);

    typedef enum logic [0:0] {
        LU_IDLE  = 1'b0,
        LU_LDUSE = 1'b1
    } lu_state_t;

    localparam logic [2:0] LU_RELOAD = 3'(LU_STALL - 1);
    localparam logic [7:0] MD_LOAD   = 8'(MD_LAT);

    lu_state_t         lu_state_q, lu_state_d;
    logic [2:0]        lu_cnt_q,   lu_cnt_d;
    logic [7:0]        md_cnt_q,   md_cnt_d;

    logic [REG_AW-1:0] rs_d, rt_d, rd_e;
    logic              hit, ctl, md_busy, md_hz;
    logic              pc_en, stall_ifid, freeze, flush_ifid, flush_idex, md_start;

    assign rs_d = bus.iRs_D;
    assign rt_d = bus.iRt_D;
    assign rd_e = bus.iRd_E;

    always_comb begin
        hit        = bus.iLoad_E && (rd_e != '0) &&
                     ((bus.iUseRs_D && (rs_d == rd_e)) || (bus.iUseRt_D && (rt_d == rd_e)));
        ctl        = bus.iBranch_E || bus.iJR_E;
        md_busy    = (md_cnt_q != 8'd0);
        md_hz      = md_busy && (bus.iHiLo_D || bus.iMulDiv_D);

        lu_state_d = lu_state_q;
        lu_cnt_d   = lu_cnt_q;
        pc_en      = 1'b1;
        stall_ifid = 1'b0;
        freeze     = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        md_start   = 1'b0;

        if (bus.iMemStall) begin
            freeze     = 1'b1;
            pc_en      = 1'b0;
            stall_ifid = 1'b1;
        end else if (ctl) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            lu_state_d = LU_IDLE;
            lu_cnt_d   = 3'd0;
        end else if (lu_state_q == LU_LDUSE) begin
            pc_en      = 1'b0;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
            lu_cnt_d   = lu_cnt_q - 3'd1;
            if (lu_cnt_q == 3'd1) begin
                lu_state_d = LU_IDLE;
            end
        end else if (hit) begin
            pc_en      = 1'b0;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
            // The first bubble is this cycle; LDUSE only covers the extra ones.
            if (LU_STALL > 1) begin
                lu_state_d = LU_LDUSE;
                lu_cnt_d   = LU_RELOAD;
            end
        end else if (md_hz) begin
            pc_en      = 1'b0;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (bus.iJump_D) begin
            flush_ifid = 1'b1;
        end else begin
            md_start   = bus.iMulDiv_D && !md_busy;
        end

        // The mul/div unit keeps counting through a freeze.
        if (md_start) begin
            md_cnt_d = MD_LOAD;
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 8'd1;
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_state_q <= LU_IDLE;
            lu_cnt_q   <= 3'd0;
            md_cnt_q   <= 8'd0;
        end else begin
            lu_state_q <= lu_state_d;
            lu_cnt_q   <= lu_cnt_d;
            md_cnt_q   <= md_cnt_d;
        end
    end

    // While in reset the pipeline is held and both stage registers flushed.
    always_comb begin
        bus.oPCEnable  = rst_n && pc_en;
        bus.oStallIFID = rst_n && stall_ifid;
        bus.oFreeze    = rst_n && freeze;
        bus.oFlushIFID = !rst_n || flush_ifid;
        bus.oFlushIDEX = !rst_n || flush_idex;
        bus.oMdStart   = rst_n && md_start;
        bus.oMdBusy    = rst_n && md_busy;
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, ~pc_en};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_ifid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign oStallCnt = stall_cnt_q;
    assign oFlushCnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_v2
// Description : Directed and randomized checks of hazard_ctrl_v2 against a
//               cycle-level behavioural model (LU_STALL=2, MD_LAT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_v2;

    localparam int REG_AW   = 5;
    localparam int LU_STALL = 2;
    localparam int MD_LAT   = 4;

    logic clk;
    logic rst_n;

    hazard_ctrl_v2_if #(.REG_AW(REG_AW)) bus ();

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    hazard_ctrl_v2 #(
        .REG_AW   (REG_AW),
        .LU_STALL (LU_STALL),
        .MD_LAT   (MD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef HAZ_PERF_EN
        ,
        .oStallCnt (stall_cnt),
        .oFlushCnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: extra load-use bubbles still owed, mul/div cycles left.
    int          owed    = 0;
    int          md_left = 0;
    int unsigned m_stalls  = 0;
    int unsigned m_flushes = 0;
    logic        m_hit, m_ctl;
    logic        e_pcen, e_stall, e_frz, e_fif, e_fid, e_start, e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        bus.iRs_D = '0; bus.iRt_D = '0; bus.iUseRs_D = 0; bus.iUseRt_D = 0;
        bus.iRd_E = '0; bus.iLoad_E = 0; bus.iMulDiv_D = 0; bus.iHiLo_D = 0;
        bus.iMemStall = 0; bus.iBranch_E = 0; bus.iJR_E = 0; bus.iJump_D = 0;
    endtask

    task automatic set_ldu(input logic [4:0] rd);
        bus.iLoad_E = 1; bus.iRd_E = rd; bus.iUseRt_D = 1; bus.iRt_D = 5'd8;
    endtask

    task automatic model_eval();
        m_hit = bus.iLoad_E && (bus.iRd_E != 0) &&
                ((bus.iUseRs_D && bus.iRs_D == bus.iRd_E) ||
                 (bus.iUseRt_D && bus.iRt_D == bus.iRd_E));
        m_ctl  = bus.iBranch_E || bus.iJR_E;
        e_busy = (md_left > 0);
        e_frz = 0; e_pcen = 1; e_stall = 0; e_fif = 0; e_fid = 0; e_start = 0;
        if (bus.iMemStall) begin
            e_frz = 1; e_pcen = 0; e_stall = 1;
        end else if (m_ctl) begin
            e_fif = 1; e_fid = 1;
        end else if (owed > 0 || m_hit || (md_left > 0 && (bus.iHiLo_D || bus.iMulDiv_D))) begin
            e_pcen = 0; e_stall = 1; e_fid = 1;
        end else if (bus.iJump_D) begin
            e_fif = 1;
        end else if (bus.iMulDiv_D) begin
            e_start = 1;
        end
    endtask

    task automatic model_step();
        if (bus.iMemStall) begin
        end else if (m_ctl)    owed = 0;
        else if (owed > 0)     owed = owed - 1;
        else if (m_hit)        owed = LU_STALL - 1;
        if (e_start)           md_left = MD_LAT;
        else if (md_left > 0)  md_left = md_left - 1;
        if (!e_pcen) m_stalls++;
        if (e_fif)   m_flushes++;
    endtask

    task automatic model_reset();
        owed = 0; md_left = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // Called at the negedge: check all outputs vs model, then advance one edge.
    task automatic tick(input string tag);
        model_eval();
        chk({tag, ".pcen"},  32'(bus.oPCEnable),  32'(e_pcen));
        chk({tag, ".stall"}, 32'(bus.oStallIFID), 32'(e_stall));
        chk({tag, ".frz"},   32'(bus.oFreeze),    32'(e_frz));
        chk({tag, ".fif"},   32'(bus.oFlushIFID), 32'(e_fif));
        chk({tag, ".fid"},   32'(bus.oFlushIDEX), 32'(e_fid));
        chk({tag, ".start"}, 32'(bus.oMdStart),   32'(e_start));
        chk({tag, ".busy"},  32'(bus.oMdBusy),    32'(e_busy));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_forced(input string tag);
        chk({tag, ".pcen"},  32'(bus.oPCEnable),  0);
        chk({tag, ".stall"}, 32'(bus.oStallIFID), 0);
        chk({tag, ".frz"},   32'(bus.oFreeze),    0);
        chk({tag, ".fif"},   32'(bus.oFlushIFID), 1);
        chk({tag, ".fid"},   32'(bus.oFlushIDEX), 1);
        chk({tag, ".start"}, 32'(bus.oMdStart),   0);
        chk({tag, ".busy"},  32'(bus.oMdBusy),    0);
    endtask

    initial begin
        rst_n = 1'b1;
        set_idle();
        #1 rst_n = 1'b0;
        model_reset();

        // Reset: forced values, then idle pipeline runs freely.
        @(negedge clk);
        chk_forced("rst");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel.pcen", 32'(bus.oPCEnable), 1);
        tick("rel");

        // Load-use, two bubbles, then release.
        set_ldu(5'd8);
        @(negedge clk); chk("lu1.pcen", 32'(bus.oPCEnable), 0); tick("lu1");
        @(negedge clk); chk("lu2.pcen", 32'(bus.oPCEnable), 0); tick("lu2");
        set_idle();
        @(negedge clk); chk("lu3.pcen", 32'(bus.oPCEnable), 1); tick("lu3");
        set_ldu(5'd0);
        @(negedge clk); chk("r0.pcen", 32'(bus.oPCEnable), 1); tick("r0");

        // Branch during LDUSE cancels remaining bubble.
        set_ldu(5'd8);
        @(negedge clk); tick("lub1");
        bus.iBranch_E = 1;
        @(negedge clk);
        chk("lub2.fif", 32'(bus.oFlushIFID), 1);
        chk("lub2.pcen", 32'(bus.oPCEnable), 1);
        tick("lub2");
        set_idle();
        @(negedge clk); chk("lub3.pcen", 32'(bus.oPCEnable), 1); tick("lub3");
`ifdef HAZ_PERF_EN
        chk("perf.stall", stall_cnt, 3);
        chk("perf.flush", flush_cnt, 1);
`endif

        // Mul/div launch, then mfhi stalls while busy.
        bus.iMulDiv_D = 1;
        @(negedge clk); chk("md0.start", 32'(bus.oMdStart), 1); tick("md0");
        bus.iMulDiv_D = 0; bus.iHiLo_D = 1;
        for (int i = 0; i < MD_LAT; i++) begin
            @(negedge clk);
            chk("mdw.busy", 32'(bus.oMdBusy), 1);
            chk("mdw.pcen", 32'(bus.oPCEnable), 0);
            tick("mdw");
        end
        @(negedge clk);
        chk("mdd.busy", 32'(bus.oMdBusy), 0);
        chk("mdd.pcen", 32'(bus.oPCEnable), 1);
        tick("mdd");
        set_idle();

        // Freeze mid load-use: bubble resumes afterwards.
        set_ldu(5'd8);
        @(negedge clk); tick("fz0");
        bus.iMemStall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fz.frz", 32'(bus.oFreeze), 1);
            chk("fz.fid", 32'(bus.oFlushIDEX), 0);
            tick("fz");
        end
        bus.iMemStall = 0;
        @(negedge clk); chk("fz4.fid", 32'(bus.oFlushIDEX), 1); tick("fz4");
        set_idle();
        @(negedge clk); chk("fz5.pcen", 32'(bus.oPCEnable), 1); tick("fz5");

        // Freeze with pending branch: flush deferred to first unfrozen cycle.
        set_ldu(5'd8);
        @(negedge clk); tick("fb0");
        bus.iMemStall = 1; bus.iBranch_E = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fb.fif", 32'(bus.oFlushIFID), 0);
            tick("fb");
        end
        bus.iMemStall = 0;
        @(negedge clk); chk("fb4.fif", 32'(bus.oFlushIFID), 1); tick("fb4");
        set_idle();
        @(negedge clk); chk("fb5.pcen", 32'(bus.oPCEnable), 1); tick("fb5");

        // Asynchronous reset in the middle of LDUSE.
        set_ldu(5'd8);
        @(negedge clk); tick("ar0");
        #1 rst_n = 1'b0;
        #1 chk_forced("ar");
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        set_idle();
        @(negedge clk); chk("ar1.pcen", 32'(bus.oPCEnable), 1); tick("ar1");

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bus.iRs_D     = 5'($urandom_range(0, 3));
            bus.iRt_D     = 5'($urandom_range(0, 3));
            bus.iRd_E     = 5'($urandom_range(0, 3));
            bus.iUseRs_D  = 1'($urandom_range(0, 1));
            bus.iUseRt_D  = 1'($urandom_range(0, 1));
            bus.iLoad_E   = ($urandom_range(0, 99) < 30);
            bus.iMulDiv_D = ($urandom_range(0, 99) < 20);
            bus.iHiLo_D   = ($urandom_range(0, 99) < 20);
            bus.iMemStall = ($urandom_range(0, 99) < 12);
            bus.iBranch_E = ($urandom_range(0, 99) < 8);
            bus.iJR_E     = ($urandom_range(0, 99) < 4);
            bus.iJump_D   = ($urandom_range(0, 99) < 10);
            @(negedge clk);
            tick("rnd");
        end
`ifdef HAZ_PERF_EN
        chk("perf.stall_end", stall_cnt, m_stalls);
        chk("perf.flush_end", flush_cnt, m_flushes);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
